// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline hazard controller bus: ID/EX decode fields in, stage-register controls and perf counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       ID_rs;
  logic [4:0]       ID_rt;
  logic             ID_uses_rs;
  logic             ID_uses_rt;
  logic             EX_valid;
  logic             EX_MemRead;
  logic [4:0]       EX_rt;
  logic             EX_is_branch;
  logic             EX_branch_taken;
  logic             EX_BranchPredict;
  logic             EX_md_start;
  logic             md_done;
  logic             PC_stall;
  logic             IF_ID_stall;
  logic             IF_ID_flush;
  logic             ID_EX_stall;
  logic             ID_EX_flush;
  logic             PC_redirect;
  logic             md_error;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_valid, EX_MemRead, EX_rt,
           EX_is_branch, EX_branch_taken, EX_BranchPredict, EX_md_start, md_done,
    input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           PC_redirect, md_error, stall_count, flush_count
  );

  modport slave (
    input  ID_rs, ID_rt, ID_uses_rs, ID_uses_rt, EX_valid, EX_MemRead, EX_rt,
           EX_is_branch, EX_branch_taken, EX_BranchPredict, EX_md_start, md_done,
    output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_stall, ID_EX_flush,
           PC_redirect, md_error, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush generator for the five-stage pipeline (load-use, EX mispredict, multi-cycle MD).
// Controls are combinational from state and inputs; saturating stall/flush cycle counters.
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  pipeline_hazard_ctrl_if.slave        bus
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(MD_TIMEOUT - 1);

  state_t           r_state;
  logic [7:0]       r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_mispredict, w_md_start, w_load_use, w_rs_hit, w_rt_hit;
  logic w_pc_stall, w_if_id_stall, w_if_id_flush, w_id_ex_stall, w_id_ex_flush;
  logic w_redirect, w_md_error;

  assign w_mispredict = bus.EX_valid & bus.EX_is_branch &
                        (bus.EX_branch_taken != bus.EX_BranchPredict);
  assign w_md_start   = bus.EX_valid & bus.EX_md_start;
  assign w_rs_hit     = bus.ID_uses_rs & (bus.ID_rs == bus.EX_rt);
  assign w_rt_hit     = bus.ID_uses_rt & (bus.ID_rt == bus.EX_rt);
  assign w_load_use   = bus.EX_valid & bus.EX_MemRead & (bus.EX_rt != 5'd0) &
                        (w_rs_hit | w_rt_hit);

  always_comb begin
    w_pc_stall    = 1'b0;
    w_if_id_stall = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_stall = 1'b0;
    w_id_ex_flush = 1'b0;
    w_redirect    = 1'b0;
    w_md_error    = 1'b0;
    if (rst_n) begin
      case (r_state)
        RUN: begin
          // The ID instruction is wrong-path on a mispredict, so its load-use hazard is moot.
          if (w_mispredict) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_redirect    = 1'b1;
          end else if (w_md_start) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_stall = 1'b1;
          end else if (w_load_use) begin
            w_pc_stall    = 1'b1;
            w_if_id_stall = 1'b1;
            w_id_ex_flush = 1'b1;
          end
        end
        MD_WAIT: begin
          if (!bus.md_done) begin
            if (r_md_cnt == TO_LAST) begin
              w_md_error = 1'b1;
            end else begin
              w_pc_stall    = 1'b1;
              w_if_id_stall = 1'b1;
              w_id_ex_stall = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_md_cnt    <= 8'd0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (!w_mispredict && w_md_start) begin
            r_state  <= MD_WAIT;
            r_md_cnt <= 8'd0;
          end
        end
        MD_WAIT: begin
          if (bus.md_done || w_md_error) begin
            r_state <= RUN;
          end else begin
            r_md_cnt <= r_md_cnt + 8'd1;
          end
        end
        default: r_state <= RUN;
      endcase
      if (w_pc_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_if_id_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign bus.PC_stall    = w_pc_stall;
  assign bus.IF_ID_stall = w_if_id_stall;
  assign bus.IF_ID_flush = w_if_id_flush;
  assign bus.ID_EX_stall = w_id_ex_stall;
  assign bus.ID_EX_flush = w_id_ex_flush;
  assign bus.PC_redirect = w_redirect;
  assign bus.md_error    = w_md_error;
  assign bus.stall_count = r_stall_cnt;
  assign bus.flush_count = r_flush_cnt;

endmodule
